// File: rtl/counter_if_pkg.sv
// Shared constants and types for the counter_if block and its bench.
package counter_if_pkg;

  // Default counter width.
  localparam int unsigned COUNT_W = 4;

  // Counter value at the default width.
  typedef logic [COUNT_W-1:0] count_t;

endpackage : counter_if_pkg

// File: rtl/counter_if_if.sv
// counter_bus: bundles the counter's control inputs and its outputs.
//   clk      - interface port, the counter clock
//   rstn     - asynchronous active-low reset
//   load_en  - synchronous parallel-load enable
//   load     - parallel-load value
//   down     - 1 = decrement, 0 = increment
//   count    - registered counter value
//   rollover - high while count is all-ones
// The master modport drives the controls; the slave modport is the counter.
interface counter_bus
  import counter_if_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W
) (
  input logic clk
);

  logic             rstn;
  logic             load_en;
  logic [WIDTH-1:0] load;
  logic             down;
  logic [WIDTH-1:0] count;
  logic             rollover;

  modport master (
    input  clk,
    output rstn,
    output load_en,
    output load,
    output down,
    input  count,
    input  rollover
  );

  // Clock and reset reach the counter as plain scalar ports.
  modport slave (
    input  load_en,
    input  load,
    input  down,
    output count,
    output rollover
  );

endinterface : counter_bus

// File: rtl/counter_if.sv
// counter_if: WIDTH-bit up/down counter with synchronous parallel load.
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset, clears count to 0
//   bus  - counter_bus slave: load_en, load, down in; count, rollover out
// Priority each edge: load_en -> load, else down -> count-1, else count+1.
// Arithmetic wraps modulo 2^WIDTH. rollover is combinational &count.
module counter_if
  import counter_if_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W
) (
  input  logic       clk,
  input  logic       rstn,
  counter_bus.slave  bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-count selection; load overrides direction.
  always_comb begin
    count_d = count_q;
    if (bus.load_en) begin
      count_d = bus.load;
    end else if (bus.down) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.count    = count_q;
  // Follows count directly, so it is 0 throughout reset.
  assign bus.rollover = &count_q;

endmodule : counter_if

// File: tb/tb_counter_if.sv
// Self-checking bench for counter_if at the default width. A modulo-16
// integer model predicts every count; rollover is predicted as model == 15.
module tb_counter_if;
  import counter_if_pkg::*;

  localparam int unsigned MOD = 1 << COUNT_W;

  logic clk;
  int   checks   = 0;
  int   failures = 0;
  int   model    = 0;

  counter_bus #(.WIDTH(COUNT_W)) bus (.clk(clk));

  counter_if #(.WIDTH(COUNT_W)) dut (
    .clk  (bus.clk),
    .rstn (bus.rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both outputs against the model.
  task automatic check_state(input string tag);
    count_t exp_c;
    exp_c = COUNT_W'(model);
    check({tag, ".count"}, 32'(bus.count), 32'(exp_c));
    check({tag, ".rollover"}, 32'(bus.rollover), (model == MOD - 1) ? 32'd1 : 32'd0);
  endtask

  // Apply one cycle of controls, advance one edge, update model, check.
  task automatic step(input string tag, input logic le, input int ld, input logic dn);
    // Junk first, then real values: only the value present at the edge matters.
    bus.load_en = 1'($urandom);
    bus.load    = COUNT_W'($urandom);
    bus.down    = 1'($urandom);
    #1;
    bus.load_en = le;
    bus.load    = COUNT_W'(ld);
    bus.down    = dn;
    if (le)      model = ld % MOD;
    else if (dn) model = (model + MOD - 1) % MOD;
    else         model = (model + 1) % MOD;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  // Asynchronous reset pulse between edges, released before the next edge.
  task automatic mid_reset(input string tag);
    #2;
    bus.rstn = 1'b0;
    model    = 0;
    #1;
    check_state({tag, ".async"});
    #2;
    bus.rstn = 1'b1;
    #1;
  endtask

  initial begin
    bus.rstn    = 1'b1;
    bus.load_en = 1'b0;
    bus.load    = '0;
    bus.down    = 1'b0;
    #1;
    bus.rstn = 1'b0;
    model    = 0;
    #1;
    check_state("reset_immediate");

    // Reset held for 5 clocks with random controls.
    for (int i = 0; i < 5; i++) begin
      bus.load_en = 1'($urandom);
      bus.load    = COUNT_W'($urandom);
      bus.down    = 1'($urandom);
      @(posedge clk);
      #1;
      check_state("reset_hold");
    end

    // Release between edges, then count up through a full wrap.
    #2;
    bus.rstn = 1'b1;
    for (int i = 0; i < 16; i++) step("count_up", 1'b0, 0, 1'b0);
    check(" wrap_to_zero", 32'(bus.count), 32'd0);

    // Load takes priority over down, then count down.
    step("load_d_with_down", 1'b1, 13, 1'b1);
    check("load_d_value", 32'(bus.count), 32'hD);
    step("down_c", 1'b0, 0, 1'b1);
    check("down_c_value", 32'(bus.count), 32'hC);
    step("down_b", 1'b0, 0, 1'b1);
    check("down_b_value", 32'(bus.count), 32'hB);

    // Load 0 then decrement wraps to all-ones.
    step("load_0", 1'b1, 0, 1'b0);
    step("down_wrap_f", 1'b0, 0, 1'b1);
    check("down_wrap_rollover", 32'(bus.rollover), 32'd1);
    step("down_e", 1'b0, 0, 1'b1);
    check("down_e_rollover", 32'(bus.rollover), 32'd0);

    // Loading all-ones raises rollover straight away.
    step("load_f", 1'b1, 15, 1'b0);
    check("load_f_rollover", 32'(bus.rollover), 32'd1);
    step("reload_same_f", 1'b1, 15, 1'b1);

    // Reset dropped between edges at count 6, then counting resumes from 0.
    step("load_5", 1'b1, 5, 1'b0);
    step("up_6", 1'b0, 0, 1'b0);
    check("at_6", 32'(bus.count), 32'h6);
    mid_reset("reset_at_6");
    step("resume_1", 1'b0, 0, 1'b0);
    check("resume_value", 32'(bus.count), 32'h1);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        mid_reset("rand_reset");
      end else begin
        step("random", 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, MOD - 1)),
             1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_if
